// File: rtl/location_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// location_cmd_scheduler
//
// Arbitrates commands from two requesters (A = user buttons, B = game logic)
// and replays each accepted command to location_data as a level pulse: one
// command line high for HOLD_CYCLES, then all lines low for GAP_CYCLES.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   a_valid/a_op/a_data requester A command; a_ready = accepted this cycle
//   b_valid/b_op/b_data requester B command; b_ready = accepted this cycle
//   isSet_cethaValue .. isPlus_distValue  level command lines (at most one high)
//   set_cethaValue      value loaded by SET_CETHA, held until the next one
//   set_distValue       value loaded by SET_DIST,  held until the next one
//   busy                high in DRIVE and GAP
//   cmd_src             source of the current / last accepted command (0=A, 1=B)
//   cmd_done            one-cycle pulse on the last GAP cycle
//   err_illegal         one-cycle pulse the cycle after an illegal op is accepted
// -----------------------------------------------------------------------------
module location_cmd_scheduler #(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_valid,
    input  logic [2:0] a_op,
    input  logic [4:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [2:0] b_op,
    input  logic [4:0] b_data,
    output logic       b_ready,
    output logic       isSet_cethaValue,
    output logic       isSet_distValue,
    output logic       isMinus_cethaValue,
    output logic       isPlus_cethaValue,
    output logic       isMinus_distValue,
    output logic       isPlus_distValue,
    output logic [4:0] set_cethaValue,
    output logic [4:0] set_distValue,
    output logic       busy,
    output logic       cmd_src,
    output logic       cmd_done,
    output logic       err_illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [2:0] OP_SET_CETHA = 3'd0;
    localparam logic [2:0] OP_SET_DIST  = 3'd1;
    localparam logic [2:0] OP_LAST_OK   = 3'd5;
    localparam logic [3:0] HOLD_LAST    = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] GAP_LAST     = 4'(GAP_CYCLES - 1);
    localparam logic [4:0] DIST_INIT    = 5'd10;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] op_q, op_d;
    logic       src_q, src_d;
    logic       last_q, last_d;     // 1 = B was granted last
    logic [4:0] cetha_q, cetha_d;
    logic [4:0] dist_q, dist_d;
    logic       err_q, err_d;

    logic       grant_a, grant_b;
    logic [2:0] sel_op;
    logic [4:0] sel_data;
    logic [5:0] line_vec;

    // Round-robin: a lone requester wins; on a tie the one not granted last wins.
    // Gating with reset keeps the ready outputs low while reset is held.
    assign grant_a  = reset && (state_q == IDLE) && a_valid && (!b_valid || last_q);
    assign grant_b  = reset && (state_q == IDLE) && b_valid && (!a_valid || !last_q);
    assign sel_op   = grant_a ? a_op   : b_op;
    assign sel_data = grant_a ? a_data : b_data;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        src_d    = src_q;
        last_d   = last_q;
        cetha_d  = cetha_q;
        dist_d   = dist_q;
        err_d    = 1'b0;
        cmd_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_a || grant_b) begin
                    last_d = grant_b;
                    src_d  = grant_b;
                    if (sel_op > OP_LAST_OK) begin
                        // Illegal op is consumed but produces no command.
                        err_d = 1'b1;
                    end else begin
                        op_d    = sel_op;
                        state_d = DRIVE;
                        cnt_d   = 4'd0;
                        if (sel_op == OP_SET_CETHA) cetha_d = sel_data;
                        if (sel_op == OP_SET_DIST)  dist_d  = sel_data;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = GAP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d  = IDLE;
                    cnt_d    = 4'd0;
                    cmd_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
            cetha_q <= 5'd0;
            dist_q  <= DIST_INIT;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            src_q   <= src_d;
            last_q  <= last_d;
            cetha_q <= cetha_d;
            dist_q  <= dist_d;
            err_q   <= err_d;
        end
    end

    // Line gi is high only in DRIVE and only when the latched op equals gi,
    // so at most one line can ever be asserted.
    for (genvar gi = 0; gi < 6; gi++) begin : g_lines
        assign line_vec[gi] = (state_q == DRIVE) && (op_q == 3'(gi));
    end

    assign isSet_cethaValue   = line_vec[0];
    assign isSet_distValue    = line_vec[1];
    assign isMinus_cethaValue = line_vec[2];
    assign isPlus_cethaValue  = line_vec[3];
    assign isMinus_distValue  = line_vec[4];
    assign isPlus_distValue   = line_vec[5];

    assign a_ready        = grant_a;
    assign b_ready        = grant_b;
    assign set_cethaValue = cetha_q;
    assign set_distValue  = dist_q;
    assign busy           = (state_q != IDLE);
    assign cmd_src        = src_q;
    assign err_illegal    = err_q;

endmodule

// File: tb/tb_location_cmd_scheduler.sv
module tb_location_cmd_scheduler;

    localparam int H = 2;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       a_valid = 1'b0;
    logic [2:0] a_op = 3'd0;
    logic [4:0] a_data = 5'd0;
    logic       a_ready;
    logic       b_valid = 1'b0;
    logic [2:0] b_op = 3'd0;
    logic [4:0] b_data = 5'd0;
    logic       b_ready;
    logic       isSet_cethaValue, isSet_distValue, isMinus_cethaValue;
    logic       isPlus_cethaValue, isMinus_distValue, isPlus_distValue;
    logic [4:0] set_cethaValue, set_distValue;
    logic       busy, cmd_src, cmd_done, err_illegal;

    int n_checks = 0;
    int n_errors = 0;

    location_cmd_scheduler #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_op(a_op), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_op(b_op), .b_data(b_data), .b_ready(b_ready),
        .isSet_cethaValue(isSet_cethaValue), .isSet_distValue(isSet_distValue),
        .isMinus_cethaValue(isMinus_cethaValue), .isPlus_cethaValue(isPlus_cethaValue),
        .isMinus_distValue(isMinus_distValue), .isPlus_distValue(isPlus_distValue),
        .set_cethaValue(set_cethaValue), .set_distValue(set_distValue),
        .busy(busy), .cmd_src(cmd_src), .cmd_done(cmd_done), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // Command lines packed in op order: bit k is the line for op k.
    logic [5:0] lines;
    assign lines = {isPlus_distValue, isMinus_distValue, isPlus_cethaValue,
                    isMinus_cethaValue, isSet_distValue, isSet_cethaValue};

    // ---------------- reference model (transaction timeline) ----------------
    // cyc numbers clock cycles; a legal command accepted in cycle T occupies
    // the scheduler until cycle T+H+G, its line is high in T+1..T+H.
    int cyc = 0;
    int m_T = -1000;
    int m_op = 0;
    int m_free = 0;
    int m_last = 1;
    int m_src = 0;
    int m_cetha = 0;
    int m_dist = 10;
    int m_err_at = -1000;

    logic       e_ga, e_gb, e_busy, e_done, e_err;
    logic [5:0] e_lines;

    always_comb begin
        e_ga    = reset && (cyc >= m_free) && a_valid && (!b_valid || m_last == 1);
        e_gb    = reset && (cyc >= m_free) && b_valid && (!a_valid || m_last == 0);
        e_lines = (cyc >= m_T + 1 && cyc <= m_T + H) ? 6'(1 << m_op) : 6'd0;
        e_busy  = (cyc < m_free);
        e_done  = (cyc == m_T + H + G);
        e_err   = (cyc == m_err_at);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_T = -1000; m_free = 0; m_last = 1; m_src = 0;
            m_cetha = 0; m_dist = 10; m_err_at = -1000; m_op = 0;
        end else begin
            if (e_ga || e_gb) begin
                int op;
                int data;
                op   = e_ga ? int'(a_op) : int'(b_op);
                data = e_ga ? int'(a_data) : int'(b_data);
                m_last = e_gb ? 1 : 0;
                m_src  = m_last;
                if (op <= 5) begin
                    m_T = cyc; m_op = op; m_free = cyc + H + G + 1;
                    if (op == 0) m_cetha = data;
                    if (op == 1) m_dist = data;
                end else begin
                    m_err_at = cyc + 1;
                end
            end
            cyc = cyc + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        a_valid = 1'b0; b_valid = 1'b0;
        reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic drain();
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (H + G + 1) next_cycle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        next_cycle();
        a_valid = 1'b1; a_op = 3'd3; b_valid = 1'b1; b_op = 3'd1;
        settle();
        n_checks++; if ({a_ready, b_ready} !== 2'b00) begin n_errors++; $display("FAIL reset_ready: got %b expected 00", {a_ready, b_ready}); end
        n_checks++; if (lines !== 6'd0) begin n_errors++; $display("FAIL reset_lines: got %b expected 000000", lines); end
        n_checks++; if ({busy, cmd_done, err_illegal, cmd_src} !== 4'b0000) begin n_errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, cmd_done, err_illegal, cmd_src}); end
        n_checks++; if (set_cethaValue !== 5'd0 || set_distValue !== 5'd10) begin n_errors++; $display("FAIL reset_values: got cetha=%0d dist=%0d expected 0/10", set_cethaValue, set_distValue); end
        next_cycle();
        a_valid = 1'b0; b_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_plus_cetha();
        a_valid = 1'b1; a_op = 3'd3; a_data = 5'd5;
        settle();
        n_checks++; if ({a_ready, b_ready} !== 2'b10) begin n_errors++; $display("FAIL plus_accept: got %b expected 10", {a_ready, b_ready}); end
        next_cycle();
        a_valid = 1'b0;
        for (int k = 1; k <= H + G + 1; k++) begin
            settle();
            n_checks++; if (lines !== ((k <= H) ? 6'b001000 : 6'b000000)) begin n_errors++; $display("FAIL plus_lines T+%0d: got %b expected %b", k, lines, (k <= H) ? 6'b001000 : 6'b000000); end
            n_checks++; if (cmd_done !== (k == H + G)) begin n_errors++; $display("FAIL plus_done T+%0d: got %b expected %b", k, cmd_done, k == H + G); end
            n_checks++; if (busy !== (k <= H + G)) begin n_errors++; $display("FAIL plus_busy T+%0d: got %b expected %b", k, busy, k <= H + G); end
            next_cycle();
        end
    endtask

    task automatic test_tie();
        do_reset();
        a_valid = 1'b1; a_op = 3'd2; a_data = 5'd1;
        b_valid = 1'b1; b_op = 3'd5; b_data = 5'd2;
        settle();
        n_checks++; if ({a_ready, b_ready} !== 2'b10) begin n_errors++; $display("FAIL tie_first: got %b expected 10", {a_ready, b_ready}); end
        next_cycle();
        a_valid = 1'b0;
        for (int k = 1; k <= H + G + 1; k++) begin
            settle();
            n_checks++; if (b_ready !== (k == H + G + 1)) begin n_errors++; $display("FAIL tie_b_ready T+%0d: got %b expected %b", k, b_ready, k == H + G + 1); end
            next_cycle();
        end
        a_valid = 1'b1; a_op = 3'd3; b_op = 3'd4;
        for (int k = 1; k <= H + G + 1; k++) begin
            settle();
            n_checks++; if ({a_ready, b_ready} !== ((k == H + G + 1) ? 2'b10 : 2'b00)) begin n_errors++; $display("FAIL tie_second T+%0d: got %b expected %b", k, {a_ready, b_ready}, (k == H + G + 1) ? 2'b10 : 2'b00); end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_set_dist();
        b_valid = 1'b1; b_op = 3'd1; b_data = 5'd17;
        settle();
        n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL setd_accept: got %b expected 1", b_ready); end
        next_cycle();
        b_valid = 1'b0;
        for (int k = 1; k <= H + G + 2; k++) begin
            settle();
            n_checks++; if (set_distValue !== 5'd17) begin n_errors++; $display("FAIL setd_value T+%0d: got %0d expected 17", k, set_distValue); end
            n_checks++; if (lines !== ((k <= H) ? 6'b000010 : 6'b000000)) begin n_errors++; $display("FAIL setd_lines T+%0d: got %b expected %b", k, lines, (k <= H) ? 6'b000010 : 6'b000000); end
            n_checks++; if (cmd_src !== 1'b1) begin n_errors++; $display("FAIL setd_src T+%0d: got %b expected 1", k, cmd_src); end
            next_cycle();
        end
    endtask

    task automatic test_illegal();
        a_valid = 1'b1; a_op = 3'd7; a_data = 5'd3;
        settle();
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL illegal_accept: got %b expected 1", a_ready); end
        next_cycle();
        a_valid = 1'b0;
        settle();
        n_checks++; if (err_illegal !== 1'b1) begin n_errors++; $display("FAIL illegal_err: got %b expected 1", err_illegal); end
        n_checks++; if (lines !== 6'd0 || busy !== 1'b0) begin n_errors++; $display("FAIL illegal_idle: got lines=%b busy=%b expected 000000/0", lines, busy); end
        n_checks++; if (cmd_src !== 1'b0) begin n_errors++; $display("FAIL illegal_src: got %b expected 0", cmd_src); end
        next_cycle();
        a_valid = 1'b1; a_op = 3'd2; b_valid = 1'b1; b_op = 3'd1; b_data = 5'd9;
        settle();
        n_checks++; if ({a_ready, b_ready} !== 2'b01) begin n_errors++; $display("FAIL illegal_tie: got %b expected 01", {a_ready, b_ready}); end
        n_checks++; if (err_illegal !== 1'b0) begin n_errors++; $display("FAIL illegal_pulse: got %b expected 0", err_illegal); end
        next_cycle();
        drain();
    endtask

    task automatic test_reset_abort();
        a_valid = 1'b1; a_op = 3'd4; a_data = 5'd0;
        settle();
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL abort_accept: got %b expected 1", a_ready); end
        next_cycle();
        a_valid = 1'b0;
        reset = 1'b0;
        settle();
        n_checks++; if (lines !== 6'd0 || busy !== 1'b0) begin n_errors++; $display("FAIL abort_lines: got lines=%b busy=%b expected 000000/0", lines, busy); end
        n_checks++; if (set_distValue !== 5'd10) begin n_errors++; $display("FAIL abort_dist: got %0d expected 10", set_distValue); end
        next_cycle();
        reset = 1'b1;
        for (int k = 0; k < H + G + 2; k++) begin
            settle();
            n_checks++; if (cmd_done !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL abort_done %0d: got done=%b busy=%b expected 0/0", k, cmd_done, busy); end
            next_cycle();
        end
        a_valid = 1'b1; a_op = 3'd0; a_data = 5'd21;
        settle();
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL abort_resume: got %b expected 1", a_ready); end
        next_cycle();
        a_valid = 1'b0;
        settle();
        n_checks++; if (set_cethaValue !== 5'd21 || lines !== 6'b000001) begin n_errors++; $display("FAIL abort_setc: got cetha=%0d lines=%b expected 21/000001", set_cethaValue, lines); end
        next_cycle();
        drain();
    endtask

    task automatic test_hold_through();
        b_valid = 1'b1; b_op = 3'd2; b_data = 5'd4;
        settle();
        n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL hold_b_accept: got %b expected 1", b_ready); end
        next_cycle();
        b_valid = 1'b0; a_valid = 1'b1; a_op = 3'd5; a_data = 5'd6;
        for (int k = 1; k <= H + G + 1; k++) begin
            settle();
            n_checks++; if (a_ready !== (k == H + G + 1)) begin n_errors++; $display("FAIL hold_a_ready T+%0d: got %b expected %b", k, a_ready, k == H + G + 1); end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic acc_a, acc_b;
            if (!a_valid) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_op = 3'($urandom_range(0, 7)); a_data = 5'($urandom_range(0, 31));
            end
            if (!b_valid) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_op = 3'($urandom_range(0, 7)); b_data = 5'($urandom_range(0, 31));
            end
            settle();
            n_checks++; if ({a_ready, b_ready} !== {e_ga, e_gb}) begin n_errors++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", cyc, {a_ready, b_ready}, {e_ga, e_gb}); end
            n_checks++; if (lines !== e_lines) begin n_errors++; $display("FAIL rnd_lines cyc %0d: got %b expected %b", cyc, lines, e_lines); end
            n_checks++; if ({busy, cmd_done, err_illegal} !== {e_busy, e_done, e_err}) begin n_errors++; $display("FAIL rnd_flags cyc %0d: got %b expected %b", cyc, {busy, cmd_done, err_illegal}, {e_busy, e_done, e_err}); end
            n_checks++; if (int'(cmd_src) != m_src || int'(set_cethaValue) != m_cetha || int'(set_distValue) != m_dist) begin n_errors++; $display("FAIL rnd_state cyc %0d: got src=%0d cetha=%0d dist=%0d expected %0d/%0d/%0d", cyc, cmd_src, set_cethaValue, set_distValue, m_src, m_cetha, m_dist); end
            acc_a = a_ready;
            acc_b = b_ready;
            next_cycle();
            if (acc_a) a_valid = 1'b0;
            if (acc_b) b_valid = 1'b0;
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_plus_cetha();
        test_tie();
        test_set_dist();
        test_illegal();
        test_reset_abort();
        test_hold_through();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/location_cmd_scheduler.md
LOCATION_CMD_SCHEDULER -- requirements
Module: location_cmd_scheduler

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2, cycles a command line is held high (legal 1..15).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, cycles all command lines are held low after a command (legal 1..15).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports a_valid  in  1, a_op  in  3, a_data  in  5: requester A command (user buttons).
REQ-006 SHALL have port a_ready  out  1  requester A command accepted this cycle.
REQ-007 SHALL have ports b_valid  in  1, b_op  in  3, b_data  in  5: requester B command (game logic).
REQ-008 SHALL have port b_ready  out  1  requester B command accepted this cycle.
REQ-009 SHALL have ports isSet_cethaValue, isSet_distValue, isMinus_cethaValue, isPlus_cethaValue, isMinus_distValue, isPlus_distValue  out  1 each: level command lines to location_data.
REQ-010 SHALL have ports set_cethaValue  out  5 and set_distValue  out  5: load values to location_data.
REQ-011 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-012 SHALL have port cmd_src  out  1  source of the current or last accepted command (0 = A, 1 = B).
REQ-013 SHALL have port cmd_done  out  1  one-cycle pulse on the last GAP cycle.
REQ-014 SHALL have port err_illegal  out  1  one-cycle pulse the cycle after an illegal op is accepted.

Function
REQ-015 SHALL decode op as: 000 SET_CETHA, 001 SET_DIST, 010 CETHA_MINUS, 011 CETHA_PLUS, 100 DIST_MINUS, 101 DIST_PLUS; 110 and 111 are illegal.
REQ-016 SHALL implement FSM states IDLE, DRIVE and GAP, with a 4-bit phase counter.
REQ-017 SHALL drive ready signals combinationally, only in IDLE: x_ready = 1 only for the requester granted that cycle.
REQ-018 SHALL arbitrate round-robin: if only one requester is valid it is granted; if both are valid, the one not granted last wins; after reset, last-grant = B, so A wins the first tie.
REQ-019 SHALL, on accept (valid && ready) of a legal op in cycle T, latch op, data and source, then enter DRIVE at T+1.
REQ-020 SHALL load set_cethaValue (SET_CETHA) or set_distValue (SET_DIST) from data at T+1 and hold it until the next SET of that field.
REQ-021 SHALL hold exactly one command line, the one mapped from op, high during cycles T+1 .. T+HOLD_CYCLES; all other lines stay low.
REQ-022 SHALL hold all command lines low in GAP during cycles T+HOLD_CYCLES+1 .. T+HOLD_CYCLES+GAP_CYCLES, then return to IDLE.
REQ-023 SHALL allow the next accept no earlier than T+HOLD_CYCLES+GAP_CYCLES+1, giving a throughput of one command per HOLD_CYCLES+GAP_CYCLES+1 cycles.
REQ-024 SHALL, on accept of an illegal op, update last-grant, remain in IDLE, drive no command line and pulse err_illegal at T+1.
REQ-025 SHALL ignore a_op, a_data, b_op and b_data when the matching ready is low; requesters hold valid, op and data until ready.
REQ-026 SHALL keep cmd_src updated at every accept and stable while busy.
REQ-027 SHALL never assert two command lines in the same cycle.

Reset
REQ-028 SHALL, while reset = 0, asynchronously force: state IDLE, all command lines 0, a_ready = b_ready = 0, busy 0, cmd_done 0, err_illegal 0, cmd_src 0, set_cethaValue 0, set_distValue 10, last-grant B, counter 0.
REQ-029 SHALL abort a command in progress on reset assertion mid-DRIVE/GAP without completing it, and issue no cmd_done for it.
REQ-030 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification (HOLD_CYCLES=2, GAP_CYCLES=2)
REQ-031 SHALL cover: A valid, op 011 at T -> a_ready=1 at T; isPlus_cethaValue=1 at T+1..T+2, 0 at T+3..T+4; cmd_done=1 at T+4; busy=0 and IDLE at T+5.
REQ-032 SHALL cover: A and B both valid after reset -> A accepted first, B accepted at T+5; B still held valid after that -> with A valid again, A wins next.
REQ-033 SHALL cover: B op 001, data 17 -> set_distValue=17 from T+1 and held after GAP; isSet_distValue high exactly 2 cycles.
REQ-034 SHALL cover: A op 111 -> a_ready=1, err_illegal=1 at T+1, no command line asserts, busy stays 0, B granted next tie.
REQ-035 SHALL cover: reset=0 at T+1 of a DIST_MINUS -> isMinus_distValue=0 immediately, set_distValue=10, no cmd_done; a new command is accepted after release.
REQ-036 SHALL cover: a_valid held through a B command -> a_ready=0 throughout DRIVE and GAP; A accepted at the first IDLE cycle.
